// File: rtl/reorder_buffer_pkg.sv
// Shared types, default sizes and helpers for the reorder buffer.
package reorder_buffer_pkg;

   localparam int unsigned ROB_N     = 3;   // dispatch / complete / retire lanes
   localparam int unsigned ROB_SZ    = 32;  // entries, power of two
   localparam int unsigned ADDR      = 32;  // address width
   localparam int unsigned MAX_LANES = 8;   // widest lane mask popcount handles

   // One ROB slot. complete is the LSB; dispatch ignores it and the ROB tracks it separately.
   typedef struct packed {
      logic [ADDR-1:0] pc;
      logic [4:0]      dest_reg;
      logic            is_branch;
      logic            branch_taken;
      logic [ADDR-1:0] branch_target;
      logic            complete;
   } rob_entry_t;

   localparam int unsigned ROB_ENTRY = $bits(rob_entry_t);

   // Number of set bits in a (zero-extended) lane mask.
   function automatic int unsigned popcount(input logic [MAX_LANES-1:0] mask);
      int unsigned c;
      c = 0;
      for (int i = 0; i < int'(MAX_LANES); i++) begin
         c += 32'(mask[i]);
      end
      return c;
   endfunction

endpackage

// File: rtl/reorder_buffer.sv
// Circular in-order reorder buffer: N-wide dispatch, completion and retire with a
// retire-time mispredict flush. Pointers carry a wrap bit so count = tail - head.
module reorder_buffer
   import reorder_buffer_pkg::*;
#(
   parameter  int unsigned N     = ROB_N,
   parameter  int unsigned DEPTH = ROB_SZ,
   localparam int unsigned IW    = $clog2(DEPTH),
   localparam int unsigned PW    = IW + 1,
   localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic [N-1:0]           disp_valid,
   input  logic [N*ROB_ENTRY-1:0] disp_entries,
   output logic [N*IW-1:0]        disp_idxs,
   output logic [CW-1:0]          free_slots,
   output logic                   full,
   output logic                   empty,
   input  logic [N-1:0]           cdb_valid,
   input  logic [N*IW-1:0]        cdb_idx,
   input  logic [N-1:0]           cdb_branch_taken,
   input  logic [N*ADDR-1:0]      cdb_branch_target,
   output logic [N*ROB_ENTRY-1:0] head_entries,
   output logic [N-1:0]           head_valids,
   output logic [N*IW-1:0]        head_idxs,
   input  logic [N-1:0]           retire_valid,
   input  logic                   rob_mispredict,
   input  logic [IW-1:0]          rob_mispred_idx
);

   rob_entry_t        ram [DEPTH];
   rob_entry_t        head_e;
   logic [DEPTH-1:0]  valid_q, valid_d, complete_q, complete_d;
   logic [PW-1:0]     head_q, head_d, tail_q, tail_d, mp_ptr;
   logic [IW-1:0]     head_idx, tail_idx, mp_off;
   logic [CW-1:0]     count, nd, nr;
   logic [N-1:0]      disp_mask, ret_mask;

   assign head_idx   = head_q[IW-1:0];
   assign tail_idx   = tail_q[IW-1:0];
   assign count      = CW'(tail_q - head_q);
   assign free_slots = CW'(DEPTH) - count;
   assign full       = (count == CW'(DEPTH));
   assign empty      = (count == '0);

   // Flush target: pointer of the mispredicted branch (within the head window) plus one.
   assign mp_off = rob_mispred_idx - head_idx;
   assign mp_ptr = head_q + PW'(mp_off) + PW'(1);

   // Lane indices, window valids and the accepted dispatch / retire masks.
   always_comb begin
      disp_idxs   = '0;
      head_idxs   = '0;
      head_valids = '0;
      disp_mask   = '0;
      ret_mask    = '0;
      for (int w = 0; w < int'(N); w++) begin
         disp_idxs[w*IW +: IW] = tail_idx + IW'(w);
         head_idxs[w*IW +: IW] = head_idx + IW'(w);
         head_valids[w]        = CW'(w) < count;
         disp_mask[w]          = disp_valid[w] && (CW'(w) < free_slots);
         ret_mask[w]           = retire_valid[w] && (CW'(w) < count);
      end
      nd = CW'(popcount(MAX_LANES'(disp_mask)));
      nr = CW'(popcount(MAX_LANES'(ret_mask)));
   end

   // Head window read; the complete bit comes from the tracked vector, not the RAM.
   always_comb begin
      head_entries = '0;
      head_e       = '0;
      for (int w = 0; w < int'(N); w++) begin
         head_e          = ram[head_idx + IW'(w)];
         head_e.complete = complete_q[head_idx + IW'(w)];
         head_entries[w*ROB_ENTRY +: ROB_ENTRY] = head_e;
      end
   end

   // Next state: mispredict flushes everything; otherwise complete, retire, then dispatch
   // so a dispatch to the same index leaves complete cleared.
   always_comb begin
      valid_d    = valid_q;
      complete_d = complete_q;
      head_d     = head_q;
      tail_d     = tail_q;
      if (rob_mispredict) begin
         valid_d    = '0;
         complete_d = '0;
         head_d     = mp_ptr;
         tail_d     = mp_ptr;
      end else begin
         for (int w = 0; w < int'(N); w++) begin
            if (cdb_valid[w] && valid_q[cdb_idx[w*IW +: IW]]) begin
               complete_d[cdb_idx[w*IW +: IW]] = 1'b1;
            end
         end
         for (int w = 0; w < int'(N); w++) begin
            if (ret_mask[w]) valid_d[head_idx + IW'(w)] = 1'b0;
         end
         for (int w = 0; w < int'(N); w++) begin
            if (disp_mask[w]) begin
               valid_d[tail_idx + IW'(w)]    = 1'b1;
               complete_d[tail_idx + IW'(w)] = 1'b0;
            end
         end
         head_d = head_q + PW'(nr);
         tail_d = tail_q + PW'(nd);
      end
   end

   // Pointer and status-bit registers.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         valid_q    <= '0;
         complete_q <= '0;
         head_q     <= '0;
         tail_q     <= '0;
      end else begin
         valid_q    <= valid_d;
         complete_q <= complete_d;
         head_q     <= head_d;
         tail_q     <= tail_d;
      end
   end

   // Payload RAM, not reset; later dispatch writes override same-index CDB updates.
   always_ff @(posedge clock) begin
      if (!rob_mispredict) begin
         for (int w = 0; w < int'(N); w++) begin
            if (cdb_valid[w] && valid_q[cdb_idx[w*IW +: IW]]) begin
               ram[cdb_idx[w*IW +: IW]].branch_taken  <= cdb_branch_taken[w];
               ram[cdb_idx[w*IW +: IW]].branch_target <= cdb_branch_target[w*ADDR +: ADDR];
            end
         end
         for (int w = 0; w < int'(N); w++) begin
            if (disp_mask[w]) ram[tail_idx + IW'(w)] <= disp_entries[w*ROB_ENTRY +: ROB_ENTRY];
         end
      end
   end

   // Retiring lanes outside the valid head window is an upstream error.
   retire_in_window: assert property (@(posedge clock) disable iff (reset)
      (retire_valid & ~head_valids) == '0);

endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench for reorder_buffer (N=3, DEPTH=32) against a queue-based model.
module tb_reorder_buffer;
   import reorder_buffer_pkg::*;

   localparam int EW = ROB_ENTRY;

   logic           clock, reset;
   logic [2:0]     disp_valid, cdb_valid, cdb_branch_taken, head_valids, retire_valid;
   logic [3*EW-1:0] disp_entries, head_entries;
   logic [14:0]    disp_idxs, cdb_idx, head_idxs;
   logic [5:0]     free_slots;
   logic           full, empty, rob_mispredict;
   logic [95:0]    cdb_branch_target;
   logic [4:0]     rob_mispred_idx;

   int total = 0;
   int bad   = 0;

   rob_entry_t mq[$];
   int         m_head;

   reorder_buffer #(.N(3), .DEPTH(32)) dut (
      .clock(clock), .reset(reset),
      .disp_valid(disp_valid), .disp_entries(disp_entries), .disp_idxs(disp_idxs),
      .free_slots(free_slots), .full(full), .empty(empty),
      .cdb_valid(cdb_valid), .cdb_idx(cdb_idx), .cdb_branch_taken(cdb_branch_taken),
      .cdb_branch_target(cdb_branch_target),
      .head_entries(head_entries), .head_valids(head_valids), .head_idxs(head_idxs),
      .retire_valid(retire_valid), .rob_mispredict(rob_mispredict),
      .rob_mispred_idx(rob_mispred_idx)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [3*EW-1:0] rand_entries();
      logic [223:0] t;
      t = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
      return t[3*EW-1:0];
   endfunction

   function automatic rob_entry_t mk_entry(input logic [31:0] pc, input logic [4:0] rd);
      rob_entry_t e;
      e = '0;
      e.pc = pc;
      e.dest_reg = rd;
      return e;
   endfunction

   function automatic void model_reset();
      mq.delete();
      m_head = 0;
   endfunction

   // Compare every observable output against the model's current state.
   task automatic check_outputs();
      int sz;
      sz = mq.size();
      for (int w = 0; w < 3; w++) begin
         chk("disp_idx", disp_idxs[w*5 +: 5], (m_head + sz + w) % 32);
         chk("head_idx", head_idxs[w*5 +: 5], (m_head + w) % 32);
         chk("head_valid", head_valids[w], w < sz);
         if (w < sz) chk("head_entry", head_entries[w*EW +: EW], mq[w]);
      end
      chk("free_slots", free_slots, 32 - sz);
      chk("full", full, sz == 32);
      chk("empty", empty, sz == 0);
   endtask

   task automatic model_update(input logic [2:0] dv, input logic [3*EW-1:0] de,
                               input logic [2:0] cv, input logic [14:0] ci,
                               input logic [2:0] ct, input logic [95:0] cg,
                               input logic [2:0] rv, input logic mp, input logic [4:0] mpi);
      int sz, pos, nr, free;
      rob_entry_t e;
      sz = mq.size();
      if (mp) begin
         mq.delete();
         m_head = (int'(mpi) + 1) % 32;
      end else begin
         for (int w = 0; w < 3; w++) begin
            pos = (int'(ci[w*5 +: 5]) - m_head + 32) % 32;
            if (cv[w] && pos < sz) begin
               e = mq[pos];
               e.complete = 1'b1;
               e.branch_taken = ct[w];
               e.branch_target = cg[w*32 +: 32];
               mq[pos] = e;
            end
         end
         nr = 0;
         for (int w = 0; w < 3; w++) if (rv[w] && w < sz) nr++;
         repeat (nr) void'(mq.pop_front());
         m_head = (m_head + nr) % 32;
         free = 32 - sz;
         for (int w = 0; w < 3; w++) begin
            if (dv[w] && w < free) begin
               e = de[w*EW +: EW];
               e.complete = 1'b0;
               mq.push_back(e);
            end
         end
      end
   endtask

   // Called at a negedge: drive, check pre-edge outputs, advance model, cross posedge.
   task automatic step(input logic [2:0] dv, input logic [3*EW-1:0] de,
                       input logic [2:0] cv, input logic [14:0] ci,
                       input logic [2:0] ct, input logic [95:0] cg,
                       input logic [2:0] rv, input logic mp, input logic [4:0] mpi);
      disp_valid = dv; disp_entries = de;
      cdb_valid = cv; cdb_idx = ci; cdb_branch_taken = ct; cdb_branch_target = cg;
      retire_valid = rv; rob_mispredict = mp; rob_mispred_idx = mpi;
      #1;
      check_outputs();
      model_update(dv, de, cv, ci, ct, cg, rv, mp, mpi);
      @(posedge clock);
      @(negedge clock);
   endtask

   task automatic dstep(input logic [2:0] dv, input logic [2:0] rv);
      step(dv, rand_entries(), 3'b0, 15'b0, 3'b0, 96'b0, rv, 1'b0, 5'd0);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      model_reset();
   endtask

   typedef struct {
      logic [2:0] dv;
      logic [2:0] cv;
      logic [4:0] cidx;
      logic [2:0] rv;
      logic [2:0] hv;
      logic [4:0] hidx0;
      logic [5:0] free;
      logic       c0;
      logic       c1;
   } vec_t;

   vec_t        tbl[5];
   rob_entry_t  e;
   logic [3*EW-1:0] pcs;
   int          sz, nd, nrr, p, lim;
   logic [2:0]  dv, cv, rv;
   logic [14:0] ci;

   initial begin
      reset = 1'b1;
      disp_valid = '0; disp_entries = '0; cdb_valid = '0; cdb_idx = '0;
      cdb_branch_taken = '0; cdb_branch_target = '0; retire_valid = '0;
      rob_mispredict = 1'b0; rob_mispred_idx = '0;
      model_reset();
      @(negedge clock);
      @(negedge clock);
      reset = 1'b0;

      // Dispatch three, complete idx1 then idx0, retire two, then late CDB to retired idx0.
      tbl[0] = '{3'b111, 3'b000, 5'd0, 3'b000, 3'b111, 5'd0, 6'd29, 1'b0, 1'b0};
      tbl[1] = '{3'b000, 3'b001, 5'd1, 3'b000, 3'b111, 5'd0, 6'd29, 1'b0, 1'b1};
      tbl[2] = '{3'b000, 3'b001, 5'd0, 3'b000, 3'b111, 5'd0, 6'd29, 1'b1, 1'b1};
      tbl[3] = '{3'b000, 3'b000, 5'd0, 3'b011, 3'b001, 5'd2, 6'd31, 1'b0, 1'b0};
      tbl[4] = '{3'b000, 3'b001, 5'd0, 3'b000, 3'b001, 5'd2, 6'd31, 1'b0, 1'b0};
      pcs = {mk_entry(32'h8, 5'd3), mk_entry(32'h4, 5'd2), mk_entry(32'h0, 5'd1)};
      chk("reset_empty", empty, 1'b1);
      chk("first_idxs", disp_idxs, {5'd2, 5'd1, 5'd0});
      for (int i = 0; i < 5; i++) begin
         step(tbl[i].dv, pcs, tbl[i].cv, {10'b0, tbl[i].cidx}, 3'b001, {64'b0, 32'h100},
              tbl[i].rv, 1'b0, 5'd0);
         chk("tbl_hv", head_valids, tbl[i].hv);
         chk("tbl_hidx0", head_idxs[4:0], tbl[i].hidx0);
         chk("tbl_free", free_slots, tbl[i].free);
         chk("tbl_c0", head_entries[0], tbl[i].c0);
         chk("tbl_c1", head_entries[EW], tbl[i].c1);
      end

      // Asynchronous reset between edges takes effect immediately.
      dstep(3'b111, 3'b000);
      #2 reset = 1'b1;
      #1;
      chk("async_hv", head_valids, 3'b000);
      chk("async_free", free_slots, 6'd32);
      chk("async_empty", empty, 1'b1);
      model_reset();
      @(negedge clock);
      reset = 1'b0;

      // Walk head to 30, wrap dispatch, fill, overflow, and dispatch+retire while full.
      dstep(3'b111, 3'b000);
      for (int i = 0; i < 9; i++) dstep(3'b111, 3'b111);
      dstep(3'b000, 3'b111);
      chk("wrap_idxs", disp_idxs, {5'd0, 5'd31, 5'd30});
      for (int i = 0; i < 10; i++) dstep(3'b111, 3'b000);
      dstep(3'b011, 3'b000);
      chk("fill_full", full, 1'b1);
      chk("fill_free", free_slots, 6'd0);
      dstep(3'b111, 3'b000);
      chk("drop_full", full, 1'b1);
      dstep(3'b111, 3'b111);
      chk("full_dr_free", free_slots, 6'd3);

      // Mispredict at idx5 with same-cycle dispatch and CDB to idx7.
      do_reset();
      dstep(3'b111, 3'b000);
      dstep(3'b000, 3'b111);
      dstep(3'b111, 3'b000);
      dstep(3'b111, 3'b000);
      dstep(3'b011, 3'b000);
      step(3'b111, rand_entries(), 3'b001, {10'b0, 5'd7}, 3'b001, {64'b0, 32'h40},
           3'b111, 1'b1, 5'd5);
      chk("mp_empty", empty, 1'b1);
      chk("mp_head", head_idxs[4:0], 5'd6);
      chk("mp_hv", head_valids, 3'b000);
      dstep(3'b111, 3'b000);
      e = head_entries[EW +: EW];
      chk("mp_idx7_cmpl", e.complete, 1'b0);

      // Randomized traffic against the model.
      do_reset();
      for (int i = 0; i < 600; i++) begin
         sz = mq.size();
         lim = (sz < 3) ? sz : 3;
         nd = $urandom_range(0, 3);
         dv = 3'((1 << nd) - 1);
         nrr = $urandom_range(0, lim);
         rv = 3'((1 << nrr) - 1);
         cv = 3'($urandom_range(0, 7));
         ci = '0;
         for (int w = 0; w < 3; w++) begin
            if (sz > 0 && $urandom_range(0, 3) != 0)
               ci[w*5 +: 5] = 5'((m_head + $urandom_range(0, sz - 1)) % 32);
            else
               ci[w*5 +: 5] = 5'($urandom_range(0, 31));
         end
         if (sz > 0 && $urandom_range(0, 19) == 0) begin
            p = $urandom_range(0, lim - 1);
            step(dv, rand_entries(), cv, ci, 3'($urandom()), {$urandom(), $urandom(), $urandom()},
                 3'((1 << (p + 1)) - 1), 1'b1, 5'((m_head + p) % 32));
         end else begin
            step(dv, rand_entries(), cv, ci, 3'($urandom()), {$urandom(), $urandom(), $urandom()},
                 rv, 1'b0, 5'd0);
         end
      end
      #1 check_outputs();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
